tdes_sequencer: RTL and testbench

Control sequencer for the Triple-DES datapath behind the AHB-Lite slave. Accepts one 64-bit block request with the configured mode and three keys, then drives a shared single-round DES datapath through three 16-round stages (E-D-E or D-E-D) with the correct key and subkey direction per stage. Presents a held result handshake back to the slave controller. Holds no data payload; it issues only datapath control plus the selected stage key.

---
 rtl/tdes_pkg.sv | 22 ++
 rtl/tdes_stage_select.sv | 49 ++++
 rtl/tdes_sequencer.sv | 127 ++++++++++++
 tb/tb_tdes_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tdes_pkg.sv
// rtl/tdes_pkg.sv - shared types and constants for the Triple-DES sequencer
package tdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_STAGE_END,
    ST_HOLD
  } tdes_state_t;

  typedef logic [1:0] tdes_stage_t;

  localparam int ROUNDS_PER_STAGE = 16;
  localparam int NUM_STAGES       = 3;
  // Acceptance edge to first res_valid cycle: LOAD plus (rounds + stage end) per stage
  localparam int TDES_LATENCY     = 1 + NUM_STAGES * (ROUNDS_PER_STAGE + 1);

  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS_PER_STAGE - 1);
  localparam tdes_stage_t LAST_STAGE = 2'(NUM_STAGES - 1);

endpackage

// File: rtl/tdes_stage_select.sv
// rtl/tdes_stage_select.sv - maps stage and direction to stage key and subkey order
// TDES_KEYOPT2_EN: two-key 3DES, key1 stands in wherever key3 would be used.
module tdes_stage_select
  import tdes_pkg::*;
(
  input  tdes_stage_t stage,
  input  logic        encrypt,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
`ifndef TDES_KEYOPT2_EN
  input  logic [63:0] key3,
`endif
  output logic [63:0] key,
  output logic        decrypt
);

  logic [63:0] key_outer;

`ifdef TDES_KEYOPT2_EN
  assign key_outer = key1;
`else
  assign key_outer = key3;
`endif

  // Encrypt runs E(k1) D(k2) E(k3); decrypt undoes it as D(k3) E(k2) D(k1)
  always_comb begin
    key     = '0;
    decrypt = 1'b0;
    case (stage)
      2'd0: begin
        key     = encrypt ? key1 : key_outer;
        decrypt = ~encrypt;
      end
      2'd1: begin
        key     = key2;
        decrypt = encrypt;
      end
      2'd2: begin
        key     = encrypt ? key_outer : key1;
        decrypt = ~encrypt;
      end
      default: begin
        key     = '0;
        decrypt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tdes_sequencer.sv
// rtl/tdes_sequencer.sv - drives a single-round DES datapath through three 16-round stages
// TDES_KEYOPT2_EN: key3 is neither latched nor used (two-key 3DES).
module tdes_sequencer
  import tdes_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cfg_encrypt,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic        res_ready,
  output logic        res_valid,
  output logic        busy,
  output logic        dp_load,
  output logic        dp_round,
  output logic [3:0]  dp_round_idx,
  output logic        dp_decrypt,
  output logic        dp_stage_end,
  output logic [63:0] dp_key
);

  tdes_state_t state_q, state_d;
  logic [3:0]  round_q;
  tdes_stage_t stage_q;
  logic        enc_q;
  logic [63:0] key1_q, key2_q;
  logic [63:0] sel_key;
  logic        sel_decrypt;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (blk_valid) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_ROUND;
      ST_ROUND:     if (round_q == LAST_ROUND) state_d = ST_STAGE_END;
      ST_STAGE_END: begin
        if (stage_q < LAST_STAGE)       state_d = ST_ROUND;
        else if (stage_q == LAST_STAGE) state_d = ST_HOLD;
        else                            state_d = ST_IDLE;
      end
      ST_HOLD:      if (res_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Configuration is captured only at acceptance so the block in flight is immune to later changes
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      round_q <= '0;
      stage_q <= '0;
      enc_q   <= 1'b0;
      key1_q  <= '0;
      key2_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (blk_valid) begin
          round_q <= '0;
          stage_q <= '0;
          enc_q   <= cfg_encrypt;
          key1_q  <= key1;
          key2_q  <= key2;
        end
        ST_ROUND:     round_q <= round_q + 4'd1;
        ST_STAGE_END: if (stage_q < LAST_STAGE) stage_q <= stage_q + 2'd1;
        default: ;
      endcase
    end
  end

`ifndef TDES_KEYOPT2_EN
  logic [63:0] key3_q;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET)                            key3_q <= '0;
    else if (state_q == ST_IDLE && blk_valid) key3_q <= key3;
  end
`endif

  tdes_stage_select u_stage_select (
    .stage   (stage_q),
    .encrypt (enc_q),
    .key1    (key1_q),
    .key2    (key2_q),
`ifndef TDES_KEYOPT2_EN
    .key3    (key3_q),
`endif
    .key     (sel_key),
    .decrypt (sel_decrypt)
  );

  always_comb begin
    blk_ready    = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    dp_load      = 1'b0;
    dp_round     = 1'b0;
    dp_round_idx = '0;
    dp_stage_end = 1'b0;
    dp_key       = sel_key;
    dp_decrypt   = sel_decrypt;
    case (state_q)
      ST_IDLE: begin
        blk_ready  = 1'b1;
        busy       = 1'b0;
        dp_key     = '0;
        dp_decrypt = 1'b0;
      end
      ST_LOAD:      dp_load = 1'b1;
      ST_ROUND: begin
        dp_round     = 1'b1;
        dp_round_idx = round_q;
      end
      ST_STAGE_END: dp_stage_end = 1'b1;
      ST_HOLD:      res_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tdes_sequencer.sv
// tb/tb_tdes_sequencer.sv - vector-table bench for tdes_sequencer
module tb_tdes_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        cfg_encrypt = 1'b0;
  logic [63:0] key1 = '0, key2 = '0, key3 = '0;
  logic        blk_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        blk_ready, res_valid, busy, dp_load, dp_round, dp_decrypt, dp_stage_end;
  logic [3:0]  dp_round_idx;
  logic [63:0] dp_key;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] K1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] K2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] K3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] KF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] KA = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] KB = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] KC = 64'hC3C3_C3C3_C3C3_C3C3;
`ifdef TDES_KEYOPT2_EN
  localparam logic [63:0] K3_EFF = K1;
  localparam logic [63:0] KC_EFF = KA;
`else
  localparam logic [63:0] K3_EFF = K3;
  localparam logic [63:0] KC_EFF = KC;
`endif

  typedef struct {
    logic        enc;
    logic [63:0] k1, k2, k3;
    int          hold_low;
    bit          inject;
    logic [63:0] ek0, ek1, ek2;
    logic [2:0]  edec;
  } vec_t;

  vec_t vecs[5];

  tdes_sequencer dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .cfg_encrypt  (cfg_encrypt),
    .key1         (key1),
    .key2         (key2),
    .key3         (key3),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .busy         (busy),
    .dp_load      (dp_load),
    .dp_round     (dp_round),
    .dp_round_idx (dp_round_idx),
    .dp_decrypt   (dp_decrypt),
    .dp_stage_end (dp_stage_end),
    .dp_key       (dp_key)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] st(input bit rdy, input bit bsy, input bit rv,
                                    input bit ld, input bit rd, input bit se,
                                    input logic [3:0] idx);
    return {rdy, bsy, rv, ld, rd, se, idx};
  endfunction

  task automatic check_out(input string nm, input logic [9:0] es, input logic [63:0] ek, input logic ed);
    chk({nm, " ctl"}, 64'({blk_ready, busy, res_valid, dp_load, dp_round, dp_stage_end, dp_round_idx}), 64'(es));
    chk({nm, " key"}, dp_key, ek);
    chk({nm, " dec"}, 64'(dp_decrypt), 64'(ed));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_block(input vec_t v, input string nm);
    logic [63:0] ek[3];
    int s, p;
    ek[0] = v.ek0; ek[1] = v.ek1; ek[2] = v.ek2;
    check_out({nm, " idle"}, st(1, 0, 0, 0, 0, 0, 4'd0), '0, 1'b0);
    cfg_encrypt = v.enc;
    key1 = v.k1; key2 = v.k2; key3 = v.k3;
    blk_valid = 1'b1;
    res_ready = (v.hold_low == 0);
    @(negedge HCLK);
    blk_valid = 1'b0;
    check_out({nm, " load"}, st(0, 1, 0, 1, 0, 0, 4'd0), ek[0], v.edec[0]);
    for (int k = 1; k <= 51; k++) begin
      @(negedge HCLK);
      s = (k - 1) / 17;
      p = (k - 1) % 17;
      if (p < 16)
        check_out($sformatf("%s k%0d", nm, k), st(0, 1, 0, 0, 1, 0, 4'(p)), ek[s], v.edec[s]);
      else
        check_out($sformatf("%s k%0d", nm, k), st(0, 1, 0, 0, 0, 1, 4'd0), ek[s], v.edec[s]);
      if (v.inject && k == 19) begin
        blk_valid = 1'b1;
        key1 = KF;
        cfg_encrypt = ~v.enc;
      end else begin
        blk_valid = 1'b0;
      end
    end
    @(negedge HCLK);
    for (int h = 0; h < v.hold_low; h++) begin
      check_out($sformatf("%s hold%0d", nm, h), st(0, 1, 1, 0, 0, 0, 4'd0), ek[2], v.edec[2]);
      @(negedge HCLK);
    end
    check_out({nm, " hold last"}, st(0, 1, 1, 0, 0, 0, 4'd0), ek[2], v.edec[2]);
    res_ready = 1'b1;
    @(negedge HCLK);
    check_out({nm, " back idle"}, st(1, 0, 0, 0, 0, 0, 4'd0), '0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, K1, K2, K3, 0,  1'b0, K1,     K2, K3_EFF, 3'b010};
    vecs[1] = '{1'b0, K1, K2, K3, 0,  1'b0, K3_EFF, K2, K1,     3'b101};
    vecs[2] = '{1'b1, K1, K2, K3, 10, 1'b0, K1,     K2, K3_EFF, 3'b010};
    vecs[3] = '{1'b1, K1, K2, K3, 0,  1'b1, K1,     K2, K3_EFF, 3'b010};
    vecs[4] = '{1'b0, KA, KB, KC, 3,  1'b0, KC_EFF, KB, KA,     3'b101};

    repeat (2) @(negedge HCLK);
    check_out("in reset", st(1, 0, 0, 0, 0, 0, 4'd0), '0, 1'b0);
    HRESET = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 5; i++)
      run_block(vecs[i], $sformatf("vec%0d", i));

    // Reset partway through stage 1 must abort the block without any result
    cfg_encrypt = 1'b1;
    key1 = K1; key2 = K2; key3 = K3;
    blk_valid = 1'b1;
    res_ready = 1'b1;
    @(negedge HCLK);
    blk_valid = 1'b0;
    repeat (29) @(negedge HCLK);
    check_out("pre reset", st(0, 1, 0, 0, 1, 0, 4'd11), K2, 1'b1);
    HRESET = 1'b0;
    #1;
    check_out("async reset", st(1, 0, 0, 0, 0, 0, 4'd0), '0, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge HCLK);
      chk($sformatf("post reset rv c%0d", c), 64'({res_valid, blk_ready}), 64'(2'b01));
    end
    run_block(vecs[0], "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
